// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - multi-cycle fetch/decode/exec/wb control FSM for the shared-ALU arithmetic datapath
// Optional retired-instruction counter: define ARITH_SEQ_INSTR_COUNT_EN.
module arith_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        fetch_req,
  output logic        pc_enable,
  output logic        ir_enable,
  output logic        alu_src1,
  output logic [1:0]  alu_src2,
  output logic [2:0]  alu_op,
  output logic        rd_src,
  output logic        wr_enable,
  output logic        except,
  output logic [31:0] instr_count
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_EXCEPT = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic       dec_legal;
  logic [2:0] dec_op;
  logic [1:0] dec_src2;
  logic       dec_rd;

  // IR is held stable from DECODE through WB, so decode stays combinational.
  always_comb begin
    dec_legal = 1'b1;
    dec_op    = ALU_ADD;
    dec_src2  = 2'd1;
    dec_rd    = 1'b1;
    case (opcode)
      6'h00: begin
        dec_src2 = 2'd0;
        dec_rd   = 1'b0;
        case (funct)
          6'h20:   dec_op = ALU_ADD;
          6'h22:   dec_op = ALU_SUB;
          6'h24:   dec_op = ALU_AND;
          6'h25:   dec_op = ALU_OR;
          6'h26:   dec_op = ALU_XOR;
          6'h27:   dec_op = ALU_NOR;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08:   dec_op = ALU_ADD;
      6'h0c:   dec_op = ALU_AND;
      6'h0d:   dec_op = ALU_OR;
      6'h0e:   dec_op = ALU_XOR;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_EXCEPT;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_EXCEPT: state_d = ST_EXCEPT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Outputs are forced low during reset so a reset landing in WB never writes.
  always_comb begin
    fetch_req = 1'b0;
    pc_enable = 1'b0;
    ir_enable = 1'b0;
    alu_src1  = 1'b0;
    alu_src2  = 2'd0;
    alu_op    = ALU_ADD;
    rd_src    = 1'b0;
    wr_enable = 1'b0;
    except    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          fetch_req = 1'b1;
          pc_enable = mem_ready;
          ir_enable = mem_ready;
          alu_src2  = 2'd2;
        end
        ST_EXEC, ST_WB: begin
          alu_src1  = 1'b1;
          alu_src2  = dec_src2;
          alu_op    = dec_op;
          rd_src    = dec_rd;
          wr_enable = (state_q == ST_WB);
        end
        ST_EXCEPT: except = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ARITH_SEQ_INSTR_COUNT_EN
  logic [31:0] instr_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)                instr_cnt_q <= 32'h0;
    else if (state_q == ST_WB) instr_cnt_q <= instr_cnt_q + 32'd1;
  end

  assign instr_count = reset ? 32'h0 : instr_cnt_q;
`else
  assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_arith_sequencer.sv
// tb/tb_arith_sequencer.sv - scoreboard bench for arith_sequencer with directed instruction vectors
module tb_arith_sequencer;

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_AND = 3'd2;
  localparam logic [2:0] A_OR  = 3'd3;
  localparam logic [2:0] A_XOR = 3'd4;
  localparam logic [2:0] A_NOR = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h0;
  logic [5:0]  funct = 6'h0;
  logic        mem_ready = 1'b0;
  logic        fetch_req, pc_enable, ir_enable, alu_src1, rd_src, wr_enable, except;
  logic [1:0]  alu_src2;
  logic [2:0]  alu_op;
  logic [31:0] instr_count;

  arith_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .fetch_req(fetch_req), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op), .rd_src(rd_src),
    .wr_enable(wr_enable), .except(except), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] v;
    logic [31:0] c;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  logic [31:0] exp_cnt = 32'h0;

  function automatic logic [11:0] pack(input logic fr, input logic pe, input logic ie,
                                       input logic s1, input logic [1:0] s2, input logic [2:0] op,
                                       input logic rd, input logic wr, input logic ex);
    return {fr, pe, ie, s1, s2, op, rd, wr, ex};
  endfunction

  // Monitor: every cycle with a queued expectation is compared away from the rising edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e = exp_q.pop_front();
      act = {fetch_req, pc_enable, ir_enable, alu_src1, alu_src2, alu_op, rd_src, wr_enable, except};
      checks++;
      if (act !== e.v || instr_count !== e.c) begin
        errors++;
        $display("FAIL cycle_%0d outputs got %h count %h expected %h count %h",
                 e.tag, act, instr_count, e.v, e.c);
      end
    end
  end

  task automatic step(input logic rst, input logic rdy, input logic [11:0] v, input logic wb);
    exp_t e;
    reset = rst;
    mem_ready = rdy;
    e.v = v;
    e.c = rst ? 32'h0 : exp_cnt;
    e.tag = step_no;
    step_no++;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (rst) exp_cnt = 32'h0;
`ifdef ARITH_SEQ_INSTR_COUNT_EN
    else if (wb) exp_cnt = exp_cnt + 32'd1;
`else
    else if (wb) exp_cnt = 32'h0;
`endif
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 12'h0, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                           input logic [2:0] xop, input logic [1:0] xs2, input logic xrd,
                           input logic reset_in_wb);
    for (int i = 0; i < waits; i++)
      step(1'b0, 1'b0, pack(1, 0, 0, 0, 2'd2, A_ADD, 0, 0, 0), 1'b0);
    opcode = op;
    funct = fn;
    step(1'b0, 1'b1, pack(1, 1, 1, 0, 2'd2, A_ADD, 0, 0, 0), 1'b0);
    step(1'b0, 1'b0, pack(0, 0, 0, 0, 2'd0, A_ADD, 0, 0, 0), 1'b0);
    step(1'b0, 1'b1, pack(0, 0, 0, 1, xs2, xop, xrd, 0, 0), 1'b0);
    if (reset_in_wb) step(1'b1, 1'b1, 12'h0, 1'b0);
    else             step(1'b0, 1'b0, pack(0, 0, 0, 1, xs2, xop, xrd, 1, 0), 1'b1);
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input int hold);
    opcode = op;
    funct = fn;
    step(1'b0, 1'b1, pack(1, 1, 1, 0, 2'd2, A_ADD, 0, 0, 0), 1'b0);
    step(1'b0, 1'b1, pack(0, 0, 0, 0, 2'd0, A_ADD, 0, 0, 0), 1'b0);
    for (int i = 0; i < hold; i++)
      step(1'b0, i[0], pack(0, 0, 0, 0, 2'd0, A_ADD, 0, 0, 1), 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_reset(2);

    run_instr(6'h00, 6'h20, 0, A_ADD, 2'd0, 1'b0, 1'b0);
    run_instr(6'h0d, 6'h00, 3, A_OR,  2'd1, 1'b1, 1'b0);
    run_instr(6'h00, 6'h22, 0, A_SUB, 2'd0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h24, 1, A_AND, 2'd0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h25, 0, A_OR,  2'd0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h26, 0, A_XOR, 2'd0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h27, 2, A_NOR, 2'd0, 1'b0, 1'b0);
    run_instr(6'h08, 6'h3f, 0, A_ADD, 2'd1, 1'b1, 1'b0);
    run_instr(6'h0c, 6'h20, 0, A_AND, 2'd1, 1'b1, 1'b0);
    run_instr(6'h0e, 6'h27, 0, A_XOR, 2'd1, 1'b1, 1'b0);

    run_instr(6'h00, 6'h20, 0, A_ADD, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++)
      run_instr(6'h08, 6'h00, 0, A_ADD, 2'd1, 1'b1, 1'b0);

`ifdef ARITH_SEQ_INSTR_COUNT_EN
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    run_instr(6'h0e, 6'h00, 0, A_XOR, 2'd1, 1'b1, 1'b0);
`endif

    run_illegal(6'h00, 6'h21, 12);
    do_reset(1);
    step(1'b0, 1'b0, pack(1, 0, 0, 0, 2'd2, A_ADD, 0, 0, 0), 1'b0);
    run_illegal(6'h04, 6'h20, 3);
    do_reset(1);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
